// File: rtl/universal_register.sv
// ============================================================================
// Module   : universal_register
// Brief    : WIDTH-bit register with hold, parallel load, left/right shift
//            and up/down count with a registered terminal-count pulse.
//            Define UNIVERSAL_REGISTER_SATURATE_EN to make count saturate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module universal_register #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             sout,
    output logic             tc
);

    localparam logic [1:0]       c_MODE_HOLD  = 2'd0;
    localparam logic [1:0]       c_MODE_LOAD  = 2'd1;
    localparam logic [1:0]       c_MODE_SHIFT = 2'd2;
    localparam logic [1:0]       c_MODE_COUNT = 2'd3;
    localparam logic [WIDTH-1:0] c_ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic             r_tc;

    logic [WIDTH-1:0] w_q_next;
    logic             w_sout_next;
    logic             w_tc_next;
    logic             w_all_ones;
    logic             w_zero;

    assign w_all_ones = &r_q;
    assign w_zero     = ~|r_q;

    always_comb begin
        w_q_next    = r_q;
        w_sout_next = r_sout;
        w_tc_next   = 1'b0;
        if (en) begin
            case (mode)
                c_MODE_HOLD: begin
                    w_q_next = r_q;
                end
                c_MODE_LOAD: begin
                    w_q_next = d;
                end
                c_MODE_SHIFT: begin
                    if (!dir) begin
                        w_q_next    = {r_q[WIDTH-2:0], sin};
                        w_sout_next = r_q[WIDTH-1];
                    end else begin
                        w_q_next    = {sin, r_q[WIDTH-1:1]};
                        w_sout_next = r_q[0];
                    end
                end
                c_MODE_COUNT: begin
                    // tc flags the attempted terminal step, whether it wraps or saturates
                    if (!dir) begin
                        w_tc_next = w_all_ones;
`ifdef UNIVERSAL_REGISTER_SATURATE_EN
                        w_q_next  = w_all_ones ? r_q : r_q + c_ONE;
`else
                        w_q_next  = r_q + c_ONE;
`endif
                    end else begin
                        w_tc_next = w_zero;
`ifdef UNIVERSAL_REGISTER_SATURATE_EN
                        w_q_next  = w_zero ? r_q : r_q - c_ONE;
`else
                        w_q_next  = r_q - c_ONE;
`endif
                    end
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= RESET_VALUE;
            r_sout <= 1'b0;
            r_tc   <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_sout <= w_sout_next;
            r_tc   <= w_tc_next;
        end
    end

    assign q    = r_q;
    assign q_n  = ~r_q;
    assign sout = r_sout;
    assign tc   = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_universal_register.sv
// ============================================================================
// Module   : tb_universal_register
// Brief    : Directed plus randomized check of universal_register against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_universal_register;

    localparam int unsigned W     = 4;
    localparam int          c_RV  = 5;
    localparam int          c_MOD = 1 << W;
    localparam int          c_MSK = c_MOD - 1;
`ifdef UNIVERSAL_REGISTER_SATURATE_EN
    localparam bit          c_SAT = 1'b1;
`else
    localparam bit          c_SAT = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         dir;
    logic [W-1:0] d;
    logic         sin;
    logic [W-1:0] q;
    logic [W-1:0] q_n;
    logic         sout;
    logic         tc;

    int n_checks;
    int n_fail;

    int m_q;
    int m_sout;
    int m_tc;

    universal_register #(
        .WIDTH      (W),
        .RESET_VALUE(4'h5)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .mode(mode),
        .dir (dir),
        .d   (d),
        .sin (sin),
        .q   (q),
        .q_n (q_n),
        .sout(sout),
        .tc  (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour expressed as plain integer arithmetic
    task automatic model(input bit r, input bit e, input int m, input bit dr, input int dd, input bit s);
        if (r) begin
            m_q = c_RV; m_sout = 0; m_tc = 0;
        end else begin
            m_tc = 0;
            if (e) begin
                if (m == 1) begin
                    m_q = dd & c_MSK;
                end else if (m == 2) begin
                    if (!dr) begin
                        m_sout = (m_q >> (W - 1)) & 1;
                        m_q    = ((m_q * 2) + s) % c_MOD;
                    end else begin
                        m_sout = m_q % 2;
                        m_q    = (m_q / 2) + (s ? c_MOD / 2 : 0);
                    end
                end else if (m == 3) begin
                    if (!dr) begin
                        m_tc = (m_q == c_MSK);
                        m_q  = (c_SAT && m_q == c_MSK) ? c_MSK : (m_q + 1) % c_MOD;
                    end else begin
                        m_tc = (m_q == 0);
                        m_q  = (c_SAT && m_q == 0) ? 0 : (m_q + c_MOD - 1) % c_MOD;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input int m, input bit dr, input int dd, input bit s);
        rst = r; en = e; mode = m[1:0]; dir = dr; d = dd[W-1:0]; sin = s;
        @(posedge clk);
        model(r, e, m, dr, dd, s);
        #1;
        check("q",    32'(q),    32'(m_q));
        check("q_n",  32'(q_n),  32'((~m_q) & c_MSK));
        check("sout", 32'(sout), 32'(m_sout));
        check("tc",   32'(tc),   32'(m_tc));
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        m_q = 0; m_sout = 0; m_tc = 0;
        rst = 1'b1; en = 1'b0; mode = 2'd0; dir = 1'b0; d = '0; sin = 1'b0;

        // Reset dominates an active count
        step(1, 1, 3, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0);
        check("rst_q", 32'(q), 32'h5);
        check("rst_qn", 32'(q_n), 32'hA);
        step(0, 1, 3, 0, 0, 0);
        check("first_up", 32'(q), 32'h6);

        // Load then hold, including en=0 overriding a load
        step(0, 1, 1, 0, 'hC, 0);
        check("load_c", 32'(q), 32'hC);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 'h3, 1);
        step(0, 0, 1, 0, 'h3, 0);
        check("en0_hold", 32'(q), 32'hC);
        check("en0_tc", 32'(tc), 32'h0);

        // Shifts
        step(0, 1, 1, 0, 'h9, 0);
        step(0, 1, 2, 0, 0, 0);
        check("shl_q", 32'(q), 32'h2);
        check("shl_sout", 32'(sout), 32'h1);
        step(0, 1, 2, 1, 0, 1);
        check("shr_q", 32'(q), 32'h9);
        check("shr_sout", 32'(sout), 32'h0);
        step(0, 1, 2, 1, 0, 0); check("shr1", 32'(sout), 32'h1);
        step(0, 1, 2, 1, 0, 0); check("shr2", 32'(sout), 32'h0);
        step(0, 1, 2, 1, 0, 0); check("shr3", 32'(sout), 32'h0);
        step(0, 1, 2, 1, 0, 0); check("shr4", 32'(sout), 32'h1);
        check("shr_end_q", 32'(q), 32'h0);

        // Count across the terminal values
        step(0, 1, 1, 0, 'hE, 0);
        step(0, 1, 3, 0, 0, 0); check("up1_q", 32'(q), 32'hF); check("up1_tc", 32'(tc), 32'h0);
        step(0, 1, 3, 0, 0, 0); check("up2_q", 32'(q), c_SAT ? 32'hF : 32'h0); check("up2_tc", 32'(tc), 32'h1);
        step(0, 1, 3, 0, 0, 0); check("up3_q", 32'(q), c_SAT ? 32'hF : 32'h1); check("up3_tc", 32'(tc), c_SAT ? 32'h1 : 32'h0);
        step(0, 1, 1, 0, 'h1, 0);
        step(0, 1, 3, 1, 0, 0); check("dn1_q", 32'(q), 32'h0); check("dn1_tc", 32'(tc), 32'h0);
        step(0, 1, 3, 1, 0, 0); check("dn2_q", 32'(q), c_SAT ? 32'h0 : 32'hF); check("dn2_tc", 32'(tc), 32'h1);

        // Reset while a count is pending, including one that would raise tc
        step(0, 1, 1, 0, 'h7, 0);
        step(1, 1, 3, 0, 0, 0);
        check("midrst_q", 32'(q), 32'h5); check("midrst_tc", 32'(tc), 32'h0);
        step(0, 1, 0, 0, 0, 0);
        check("post_rst_tc", 32'(tc), 32'h0);
        step(0, 1, 1, 0, 'hF, 0);
        step(1, 1, 3, 0, 0, 0);
        check("rst_tc_pend", 32'(tc), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) != 0),
                 int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, c_MSK)), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised WIDTH-bit register built on positive-edge flip-flops. It is the multi-bit successor to the single-bit D flop.
- Supports four modes: hold, parallel load, serial shift (left/right) and up/down count with a terminal-count pulse.
- Used by the clock-divider and auto-decoder test datapaths as a general-purpose state register, shifter and counter.
- All state updates on the rising edge of clk only.

Parameters:
- WIDTH, 4, register width in bits (>=2).
- RESET_VALUE, 0, value loaded into q on reset (WIDTH bits, truncated if wider).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous active-high reset.
- en  input  1  operation enable; 0 forces hold regardless of mode.
- mode  input  2  0=hold, 1=load, 2=shift, 3=count.
- dir  input  1  shift: 0=left, 1=right; count: 0=up, 1=down.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial input bit for shift.
- q  output  WIDTH  register contents.
- q_n  output  WIDTH  bitwise complement of q, combinational.
- sout  output  1  registered bit shifted out on the last shift.
- tc  output  1  registered terminal-count pulse.

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst. Sampled at the rising edge only; no asynchronous path.
- Reset has highest priority, above en and mode. Reset values:
  - q=RESET_VALUE
  - q_n=~RESET_VALUE
  - sout=0
  - tc=0
- Reset asserted mid-operation discards the current mode. Operation resumes from RESET_VALUE on the first edge after rst deasserts.
- en=0: q and sout hold; tc=0 on the next edge.
- en=1, mode 0 (hold): q and sout hold; tc=0.
- en=1, mode 1 (load): q<=d; sout holds; tc=0. Latency 1 cycle (d visible on q after the edge).
- en=1, mode 2, dir 0 (shift left): q<={q[WIDTH-2:0],sin}; sout<=q[WIDTH-1]; tc=0.
- en=1, mode 2, dir 1 (shift right): q<={sin,q[WIDTH-1:1]}; sout<=q[0]; tc=0.
- en=1, mode 3, dir 0 (count up): q<=q+1 modulo 2^WIDTH; tc<=1 if q was all-ones before the edge, else 0.
- en=1, mode 3, dir 1 (count down): q<=q-1 modulo 2^WIDTH; tc<=1 if q was zero before the edge, else 0.
- tc is a single-cycle pulse per terminal step. Consecutive terminal steps give consecutive pulses. tc never asserts outside mode 3.
- Switching mode or dir between cycles takes effect on the next edge with no dead cycle.
- Arithmetic is unsigned, WIDTH bits, with no carry-out port. tc is the only overflow indication.
- q_n always equals ~q, including during reset; no extra latency.
- No X on any output after the first reset edge. All inputs are assumed synchronous to clk.

Optional Feature:
- Macro: UNIVERSAL_REGISTER_SATURATE_EN.
- Defined: count mode saturates instead of wrapping.
  - Up at all-ones leaves q at all-ones.
  - Down at zero leaves q at zero.
  - tc still pulses for every count step attempted at the terminal value.
- Undefined: modulo wrap as specified in Behaviour.
- All other modes are unaffected.

Test Plan:
- Reset: WIDTH=4, RESET_VALUE=4'h5; drive rst=1 with en=1, mode=3 for 2 edges -> q=5, q_n=4'hA, sout=0, tc=0; release rst -> first count-up edge gives q=6.
- Load then hold: en=1, mode=1, d=4'hC for 1 edge -> q=C; then mode=0 for 3 edges, and separately en=0 with mode=1, d=3 -> q stays C, tc=0.
- Shift: q=4'b1001; mode=2, dir=0, sin=0 -> q=0010, sout=1. Then dir=1, sin=1 -> q=1001, sout=0. Four right shifts with sin=0 from 1001 -> q=0000, sout sequence 1,0,0,1.
- Count wrap: q=4'hE, mode=3, dir=0 for 3 edges -> q=F,0,1; tc=0,1,0. Then dir=1 from 1 for 2 edges -> q=0,F; tc=0,1.
- Saturate (macro defined): q=4'hE, count up 3 edges -> q=F,F,F; tc=0,1,1. Down from 1 for 2 edges -> q=0,0; tc=0,1.
- Reset mid-count: counting up at q=7, assert rst for 1 edge -> q=RESET_VALUE, tc=0 even though the step was pending; no stale tc after release.
